// File: rtl/wb_scoreboard.sv
// Register scoreboard and writeback arbiter: tracks destinations of in-flight long-latency ops,
// stalls dependent issue, and funnels short/load/mul/div results into one registered RF write port.
module wb_scoreboard #(
  parameter int LONG_MAX = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_instruction_vld,
  input  logic [4:0]  i_rs1_index,
  input  logic [4:0]  i_rs2_index,
  input  logic [4:0]  i_rd_index,
  input  logic        i_rs1_mark,
  input  logic        i_rs2_mark,
  input  logic        i_rd_mark,
  input  logic        i_rd_long_mark,
  output logic        o_conflict,
  input  logic        i_short_vld,
  input  logic [4:0]  i_short_rd,
  input  logic [31:0] i_short_data,
  input  logic        i_load_vld,
  input  logic [4:0]  i_load_rd,
  input  logic [31:0] i_load_data,
  input  logic        i_mul_vld,
  input  logic [4:0]  i_mul_rd,
  input  logic [31:0] i_mul_data,
  input  logic        i_div_vld,
  input  logic [4:0]  i_div_rd,
  input  logic [31:0] i_div_data,
  output logic        o_load_rdy,
  output logic        o_mul_rdy,
  output logic        o_div_rdy,
  output logic        o_rf_we,
  output logic [4:0]  o_rf_waddr,
  output logic [31:0] o_rf_wdata,
  output logic [31:0] o_busy,
  output logic [3:0]  o_long_cnt
);

  typedef struct packed {
    logic        vld;
    logic        lng;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  logic [31:0] r_busy, w_busy_nxt;
  logic [3:0]  r_long_cnt, w_cnt_nxt;
  logic        r_rf_we;
  logic [4:0]  r_rf_waddr;
  logic [31:0] r_rf_wdata;
  logic        w_fire, w_inc, w_full;
  wb_t         w_wb;

  assign w_full = (r_long_cnt == 4'(LONG_MAX));

  // Hazard check uses only registered busy; a clear landing this cycle is seen next cycle.
  assign o_conflict = i_instruction_vld &
                      ((i_rs1_mark & r_busy[i_rs1_index]) |
                       (i_rs2_mark & r_busy[i_rs2_index]) |
                       (i_rd_mark  & r_busy[i_rd_index])  |
                       (i_rd_long_mark & w_full));

  assign w_fire = i_instruction_vld & ~o_conflict;
  assign w_inc  = w_fire & i_rd_long_mark;

  assign o_load_rdy = ~i_short_vld;
  assign o_mul_rdy  = ~i_short_vld & ~i_load_vld;
  assign o_div_rdy  = ~i_short_vld & ~i_load_vld & ~i_mul_vld;

  always_comb begin
    w_wb = '0;
    if (i_short_vld)     w_wb = '{vld: 1'b1, lng: 1'b0, rd: i_short_rd, data: i_short_data};
    else if (i_load_vld) w_wb = '{vld: 1'b1, lng: 1'b1, rd: i_load_rd,  data: i_load_data};
    else if (i_mul_vld)  w_wb = '{vld: 1'b1, lng: 1'b1, rd: i_mul_rd,   data: i_mul_data};
    else if (i_div_vld)  w_wb = '{vld: 1'b1, lng: 1'b1, rd: i_div_rd,   data: i_div_data};
  end

  // Clear before set so a same-index issue and completion leaves the bit set.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wb.lng) w_busy_nxt[w_wb.rd] = 1'b0;
    if (w_inc && (i_rd_index != 5'd0)) w_busy_nxt[i_rd_index] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_comb begin
    w_cnt_nxt = r_long_cnt;
    if (w_inc && !w_wb.lng) w_cnt_nxt = r_long_cnt + 4'd1;
    else if (!w_inc && w_wb.lng && (r_long_cnt != 4'd0)) w_cnt_nxt = r_long_cnt - 4'd1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_busy     <= '0;
      r_long_cnt <= '0;
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_long_cnt <= w_cnt_nxt;
      r_rf_we    <= w_wb.vld & (w_wb.rd != 5'd0);
      if (w_wb.vld) begin
        r_rf_waddr <= w_wb.rd;
        r_rf_wdata <= w_wb.data;
      end
    end
  end

  assign o_busy     = r_busy;
  assign o_long_cnt = r_long_cnt;
  assign o_rf_we    = r_rf_we;
  assign o_rf_waddr = r_rf_waddr;
  assign o_rf_wdata = r_rf_wdata;

endmodule

// File: tb/tb_wb_scoreboard.sv
// Scoreboard bench for wb_scoreboard: directed scenarios then constrained-random traffic,
// checked against a rule-level model; RF writes are queued and matched by a separate monitor.
module tb_wb_scoreboard;
  localparam int LONG_MAX = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, ivld, rs1_mark, rs2_mark, rd_mark, rd_long_mark;
  logic [4:0]  rs1_index, rs2_index, rd_index;
  logic        short_vld, load_vld, mul_vld, div_vld;
  logic [4:0]  short_rd, load_rd, mul_rd, div_rd;
  logic [31:0] short_data, load_data, mul_data, div_data;
  logic        conflict, load_rdy, mul_rdy, div_rdy, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, busy;
  logic [3:0]  long_cnt;

  wb_scoreboard #(.LONG_MAX(LONG_MAX)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_instruction_vld(ivld),
    .i_rs1_index(rs1_index), .i_rs2_index(rs2_index), .i_rd_index(rd_index),
    .i_rs1_mark(rs1_mark), .i_rs2_mark(rs2_mark), .i_rd_mark(rd_mark),
    .i_rd_long_mark(rd_long_mark), .o_conflict(conflict),
    .i_short_vld(short_vld), .i_short_rd(short_rd), .i_short_data(short_data),
    .i_load_vld(load_vld), .i_load_rd(load_rd), .i_load_data(load_data),
    .i_mul_vld(mul_vld), .i_mul_rd(mul_rd), .i_mul_data(mul_data),
    .i_div_vld(div_vld), .i_div_rd(div_rd), .i_div_data(div_data),
    .o_load_rdy(load_rdy), .o_mul_rdy(mul_rdy), .o_div_rdy(div_rdy),
    .o_rf_we(rf_we), .o_rf_waddr(rf_waddr), .o_rf_wdata(rf_wdata),
    .o_busy(busy), .o_long_cnt(long_cnt)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];

  // reference model state
  bit          m_busy[32];
  int          m_cnt;
  bit          m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  int          acc_src;   // 0 none, 1 short, 2 load, 3 mul, 4 div
  bit          fired_long;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // RF write monitor: every DUT write must match the oldest expected write.
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rf_write_unexpected: got x%0d=%h expected none", rf_waddr, rf_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("rf_write_addr", {27'd0, rf_waddr}, {27'd0, e.rd});
        chk("rf_write_data", rf_wdata, e.data);
      end
    end
  end

  task automatic idle();
    ivld = 0; rs1_mark = 0; rs2_mark = 0; rd_mark = 0; rd_long_mark = 0;
    rs1_index = 0; rs2_index = 0; rd_index = 0;
    short_vld = 0; load_vld = 0; mul_vld = 0; div_vld = 0;
    short_rd = 0; load_rd = 0; mul_rd = 0; div_rd = 0;
    short_data = 0; load_data = 0; mul_data = 0; div_data = 0;
  endtask

  // Called ~1ns after a rising edge with inputs already driven; checks, advances model, crosses one edge.
  task automatic step();
    bit e_conf;
    logic [31:0] e_busy;
    logic [4:0] a_rd;
    logic [31:0] a_data;
    #1;
    e_conf = ivld && ((rs1_mark && m_busy[rs1_index]) || (rs2_mark && m_busy[rs2_index]) ||
                      (rd_mark && m_busy[rd_index]) || (rd_long_mark && m_cnt == LONG_MAX));
    for (int i = 0; i < 32; i++) e_busy[i] = m_busy[i];
    chk("conflict", {31'd0, conflict}, {31'd0, e_conf});
    chk("load_rdy", {31'd0, load_rdy}, {31'd0, !short_vld});
    chk("mul_rdy",  {31'd0, mul_rdy},  {31'd0, !short_vld && !load_vld});
    chk("div_rdy",  {31'd0, div_rdy},  {31'd0, !short_vld && !load_vld && !mul_vld});
    chk("busy", busy, e_busy);
    chk("long_cnt", {28'd0, long_cnt}, 32'(m_cnt));
    chk("rf_we", {31'd0, rf_we}, {31'd0, m_we});
    chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, m_waddr});
    chk("rf_wdata", rf_wdata, m_wdata);

    acc_src = 0; a_rd = 0; a_data = 0;
    if (short_vld)     begin acc_src = 1; a_rd = short_rd; a_data = short_data; end
    else if (load_vld) begin acc_src = 2; a_rd = load_rd;  a_data = load_data;  end
    else if (mul_vld)  begin acc_src = 3; a_rd = mul_rd;   a_data = mul_data;   end
    else if (div_vld)  begin acc_src = 4; a_rd = div_rd;   a_data = div_data;   end
    fired_long = ivld && !e_conf && rd_long_mark;

    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 0;
      m_cnt = 0; m_we = 0; m_waddr = 0; m_wdata = 0;
      acc_src = 0; fired_long = 0;
    end else begin
      m_we = (acc_src != 0) && (a_rd != 0);
      if (acc_src != 0) begin
        m_waddr = a_rd; m_wdata = a_data;
        if (a_rd != 0) exp_q.push_back('{rd: a_rd, data: a_data});
      end
      if (acc_src >= 2) m_busy[a_rd] = 0;
      if (fired_long && rd_index != 0) m_busy[rd_index] = 1;
      if (fired_long && acc_src < 2) m_cnt++;
      else if (!fired_long && acc_src >= 2 && m_cnt > 0) m_cnt--;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue_long(input logic [4:0] rd);
    idle(); ivld = 1; rd_index = rd; rd_mark = 1; rd_long_mark = 1;
    step();
  endtask

  task automatic accept_mul(input logic [4:0] rd, input logic [31:0] d);
    idle(); mul_vld = 1; mul_rd = rd; mul_data = d;
    step();
  endtask

  // random long-source bookkeeping
  wr_t pl[$], pm[$], pd[$];
  bit  pres_l, pres_m, pres_d;

  initial begin
    rst_n = 0; idle();
    @(posedge clk); #1;
    step();                               // reset state
    rst_n = 1;

    // dependent issue after LOAD, then writeback clears the hazard
    issue_long(5);
    idle(); ivld = 1; rs1_index = 5; rs1_mark = 1; step();
    idle(); load_vld = 1; load_rd = 5; load_data = 32'hDEADBEEF; step();
    idle(); ivld = 1; rs1_index = 5; rs1_mark = 1; step();

    // short beats load in the same cycle
    issue_long(7);
    idle(); short_vld = 1; short_rd = 3; short_data = 32'h0000_3333;
    load_vld = 1; load_rd = 7; load_data = 32'h7777_0007; step();
    short_vld = 0; step();

    // load, mul, div all pending: drained in priority order
    issue_long(10); issue_long(11); issue_long(12);
    idle(); load_vld = 1; load_rd = 10; load_data = 32'hA;
    mul_vld = 1; mul_rd = 11; mul_data = 32'hB;
    div_vld = 1; div_rd = 12; div_data = 32'hC; step();
    load_vld = 0; step();
    mul_vld = 0; step();
    div_vld = 0; step();

    // long-op limit
    for (int r = 1; r <= LONG_MAX; r++) issue_long(5'(r));
    idle(); ivld = 1; rd_index = 8; rd_mark = 1; rd_long_mark = 1; step();
    mul_vld = 1; mul_rd = 1; mul_data = 32'h1111; step();
    mul_vld = 0; step();                  // now fires
    accept_mul(2, 32'h2); accept_mul(3, 32'h3); accept_mul(4, 32'h4); accept_mul(8, 32'h8);

    // x0 destinations
    idle(); short_vld = 1; short_rd = 0; short_data = 32'h1234; step();
    issue_long(0);
    accept_mul(0, 32'h5555);
    idle(); step();

    // reset mid-operation
    issue_long(9); issue_long(20);
    idle(); rst_n = 0; load_vld = 1; load_rd = 9; load_data = 32'h99; step();
    rst_n = 1;
    idle(); ivld = 1; rs1_index = 9; rs1_mark = 1; step();

    // constrained-random traffic
    pres_l = 0; pres_m = 0; pres_d = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!pres_l && pl.size() > 0 && $urandom_range(0, 1) == 1) begin
        pres_l = 1; load_rd = pl[0].rd; load_data = pl[0].data;
      end
      if (!pres_m && pm.size() > 0 && $urandom_range(0, 1) == 1) begin
        pres_m = 1; mul_rd = pm[0].rd; mul_data = pm[0].data;
      end
      if (!pres_d && pd.size() > 0 && $urandom_range(0, 1) == 1) begin
        pres_d = 1; div_rd = pd[0].rd; div_data = pd[0].data;
      end
      load_vld = pres_l; mul_vld = pres_m; div_vld = pres_d;
      short_vld  = ($urandom_range(0, 3) == 0);
      short_rd   = 5'($urandom_range(0, 31));
      short_data = $urandom;
      ivld         = ($urandom_range(0, 1) == 1);
      rs1_index    = 5'($urandom_range(0, 7));
      rs2_index    = 5'($urandom_range(0, 7));
      rd_index     = 5'($urandom_range(0, 7));
      rs1_mark     = $urandom_range(0, 1) == 1;
      rs2_mark     = $urandom_range(0, 1) == 1;
      rd_long_mark = $urandom_range(0, 2) == 0;
      rd_mark      = rd_long_mark || ($urandom_range(0, 1) == 1);
      rst_n        = ($urandom_range(0, 299) != 0);
      step();
      if (!rst_n) begin
        pl.delete(); pm.delete(); pd.delete();
        pres_l = 0; pres_m = 0; pres_d = 0;
      end else begin
        if (acc_src == 2) begin void'(pl.pop_front()); pres_l = 0; end
        if (acc_src == 3) begin void'(pm.pop_front()); pres_m = 0; end
        if (acc_src == 4) begin void'(pd.pop_front()); pres_d = 0; end
        if (fired_long) begin
          case ($urandom_range(0, 2))
            0: pl.push_back('{rd: rd_index, data: $urandom});
            1: pm.push_back('{rd: rd_index, data: $urandom});
            default: pd.push_back('{rd: rd_index, data: $urandom});
          endcase
        end
      end
    end

    rst_n = 1; idle();
    repeat (3) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rf_write_missing: got %0d outstanding expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_scoreboard.md
WB_SCOREBOARD -- requirements
Module: wb_scoreboard

Interface
REQ-001 Parameter: LONG_MAX, default 4, maximum in-flight long-latency ops (LOAD/MUL/DIV), range 1..15.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset; synchronous, active-low.
REQ-004 instruction_vld  in  1  decoded instruction present at issue.
REQ-005 rs1_index, rs2_index, rd_index  in  5 each  operand/destination indices from decode.
REQ-006 rs1_mark, rs2_mark, rd_mark, rd_long_mark  in  1 each  decode usage flags; rd_long_mark implies rd_mark.
REQ-007 conflict  out  1  issue stall to decode.
REQ-008 short_vld  in  1; short_rd  in  5; short_data  in  32  single-cycle result (ALU/BIT/JAL/JALR/LUI/AUIPC/CSR); no ready, always accepted.
REQ-009 load_vld, mul_vld, div_vld  in  1 each; load_rd, mul_rd, div_rd  in  5 each; load_data, mul_data, div_data  in  32 each  long-result sources.
REQ-010 load_rdy, mul_rdy, div_rdy  out  1 each  long-result acceptance.
REQ-011 rf_we  out  1; rf_waddr  out  5; rf_wdata  out  32  registered register-file write port.
REQ-012 busy  out  32  scoreboard state, bit i = x(i) awaiting long result.
REQ-013 long_cnt  out  4  in-flight long-op count.

Function
REQ-014 conflict = instruction_vld & (rs1_mark & busy[rs1_index] | rs2_mark & busy[rs2_index] | rd_mark & busy[rd_index] | rd_long_mark & long_cnt==LONG_MAX); combinational, from registered busy only (no same-cycle clear bypass).
REQ-015 Issue fire = instruction_vld & ~conflict.
REQ-016 On fire with rd_long_mark and rd_index != 0: busy[rd_index] set next cycle.
REQ-017 On fire with rd_long_mark (any rd, including x0): long_cnt increments.
REQ-018 busy[0] SHALL read 0 always.
REQ-019 Writeback priority per cycle: short > load > mul > div; exactly one source accepted.
REQ-020 load_rdy = ~short_vld; mul_rdy = ~short_vld & ~load_vld; div_rdy = ~short_vld & ~load_vld & ~mul_vld; combinational.
REQ-021 Long transfer completes when X_vld & X_rdy; source holds vld/rd/data stable until accepted.
REQ-022 On long acceptance: busy[X_rd] cleared next cycle, long_cnt decrements.
REQ-023 Same-cycle long issue and long acceptance: long_cnt unchanged; set/clear of same busy index resolves to set.
REQ-024 long_cnt SHALL never exceed LONG_MAX nor underflow; acceptance with long_cnt==0 is a protocol error, count held at 0.
REQ-025 Accepted result latched into rf_waddr/rf_wdata next cycle; rf_we = 1 for that cycle iff dest != 0.
REQ-026 No accepted result: rf_we = 0 next cycle; rf_waddr/rf_wdata hold previous value.
REQ-027 Latency: result accept to rf_we = 1 cycle; issue to busy visible in conflict = 1 cycle.
REQ-028 Short results do not touch busy or long_cnt.

Reset
REQ-029 rst_n low at clock edge: busy = 0, long_cnt = 0, rf_we = 0, rf_waddr = 0, rf_wdata = 0.
REQ-030 Reset mid-operation discards in-flight tracking; result handshakes during reset are not written back; rdy outputs follow REQ-020 combinationally.

Verification
REQ-031 Issue LOAD rd=5 (rd_long_mark), next cycle ADD rs1=5 -> conflict=1; load_vld rd=5 data=0xDEADBEEF -> following cycle rf_we=1, waddr=5, wdata=0xDEADBEEF; next cycle busy[5]=0, conflict=0.
REQ-032 short_vld rd=3 and load_vld rd=7 same cycle -> load_rdy=0, x3 written first; next cycle load accepted, x7 written.
REQ-033 load, mul, div valid together, no short -> written in order load, mul, div over 3 consecutive cycles; long_cnt 3->0.
REQ-034 Issue LONG_MAX=4 MULs rd=1..4 -> long_cnt=4; fifth MUL rd=8 -> conflict=1; one mul acceptance -> conflict=0 next cycle.
REQ-035 Short result rd=0 data=0x1234 -> rf_we=0; MUL rd=0 issued -> busy stays 0, long_cnt increments, decrements on acceptance.
REQ-036 busy[9] set, long_cnt=2, rst_n low one cycle -> busy=0, long_cnt=0, rf_we=0, conflict=0 for rs1=9.
